// File: rtl/pcie_cv_qsys_onchip_memory_burst.sv
// On-chip single-port RAM behind a burst-capable slave port.
// Reads return sequential beats with latency 1 (or 2 with OUTPUT_REG); writes take one beat per
// accepted cycle. clken low or reset_req high freezes the whole block.
module pcie_cv_qsys_onchip_memory_burst #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned BURST_WIDTH = 4,
   parameter int unsigned OUTPUT_REG  = 0,
   parameter int unsigned READ_ONLY   = 0,
   parameter string       INIT_FILE   = "pcie_cv_qsys_onchip_memory_burst.hex"
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_req,
   input  logic                    clken,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [BURST_WIDTH-1:0]  burstcount,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic                    waitrequest,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid
);

   localparam int unsigned Depth    = 1 << ADDR_WIDTH;
   localparam int unsigned NumBytes = DATA_WIDTH / 8;

   typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_d;

   logic                   stall;
   logic                   accept;
   logic                   multi;
   logic                   mem_we;
   logic                   mem_re;
   logic [ADDR_WIDTH-1:0]  mem_addr;

   logic [DATA_WIDTH-1:0]  mem [Depth];

   logic                   rd_v_q;
   logic [DATA_WIDTH-1:0]  rd_d_q;
   logic                   out_v;
   logic [DATA_WIDTH-1:0]  out_d;
   logic [DATA_WIDTH-1:0]  last_q;

   assign stall       = ~clken | reset_req;
   assign waitrequest = stall | (state_q == StRdBurst);
   assign accept      = chipselect & (read | write) & ~waitrequest;
   // burstcount of 0 or 1 is a single beat
   assign multi       = burstcount > BURST_WIDTH'(1);

   // Next-state, burst counters and memory port control.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      mem_addr = addr_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mem_addr = address;
               // write wins when both commands arrive together
               mem_we   = write;
               mem_re   = ~write;
               addr_d   = address + ADDR_WIDTH'(1);
               cnt_d    = multi ? (burstcount - BURST_WIDTH'(1)) : '0;
               if (multi) state_d = write ? StWrBurst : StRdBurst;
            end
         end
         StRdBurst: begin
            if (~stall) begin
               mem_re = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               cnt_d  = cnt_q - BURST_WIDTH'(1);
               if (cnt_q == BURST_WIDTH'(1)) state_d = StIdle;
            end
         end
         StWrBurst: begin
            // read, address and burstcount are ignored here
            if (~stall & chipselect & write) begin
               mem_we = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               cnt_d  = cnt_q - BURST_WIDTH'(1);
               if (cnt_q == BURST_WIDTH'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and burst address/count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else if (~stall) begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Byte-masked memory write; suppressed entirely for read-only instances.
   always_ff @(posedge clk) begin
      if (READ_ONLY == 0 && mem_we && !reset) begin
         for (int unsigned b = 0; b < NumBytes; b++) begin
            if (byteenable[b]) mem[mem_addr][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   // First read stage: synchronous memory read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_v_q <= 1'b0;
         rd_d_q <= '0;
      end else if (~stall) begin
         rd_v_q <= mem_re;
         if (mem_re) rd_d_q <= mem[mem_addr];
      end
   end

   if (OUTPUT_REG != 0) begin : g_out_reg
      logic                  o_v_q;
      logic [DATA_WIDTH-1:0] o_d_q;

      // Optional second read stage for a two-cycle latency.
      always_ff @(posedge clk) begin
         if (reset) begin
            o_v_q <= 1'b0;
            o_d_q <= '0;
         end else if (~stall) begin
            o_v_q <= rd_v_q;
            if (rd_v_q) o_d_q <= rd_d_q;
         end
      end

      assign out_v = o_v_q;
      assign out_d = o_d_q;
   end else begin : g_no_out_reg
      assign out_v = rd_v_q;
      assign out_d = rd_d_q;
   end

   // A beat sitting at the output is only presented on non-stalled cycles.
   assign readdatavalid = out_v & ~stall;
   assign readdata      = readdatavalid ? out_d : last_q;

   // Remember the last presented beat so readdata holds between beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
      end else if (readdatavalid) begin
         last_q <= out_d;
      end
   end

endmodule

// File: tb/tb_pcie_cv_qsys_onchip_memory_burst.sv
// Bench: two read/write instances (latency 1 and 2) and one read-only instance share stimulus.
// A transaction-level model predicts waitrequest and the ordered stream of read beats.
module tb_pcie_cv_qsys_onchip_memory_burst;

   logic        clk = 1'b0;
   logic        reset, reset_req, clken, cs, rd, wr;
   logic [9:0]  addr;
   logic [3:0]  bc;
   logic [3:0]  be;
   logic [31:0] wd;
   logic        wait0, wait1, wait_ro, rdv0, rdv1, rdv_ro;
   logic [31:0] rdd0, rdd1, rdd_ro;

   pcie_cv_qsys_onchip_memory_burst #(
      .OUTPUT_REG(0), .READ_ONLY(0), .INIT_FILE("")
   ) u_rw0 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(cs),
      .read(rd), .write(wr), .address(addr), .burstcount(bc), .byteenable(be),
      .writedata(wd), .waitrequest(wait0), .readdata(rdd0), .readdatavalid(rdv0)
   );

   pcie_cv_qsys_onchip_memory_burst #(
      .OUTPUT_REG(1), .READ_ONLY(0), .INIT_FILE("")
   ) u_rw1 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(cs),
      .read(rd), .write(wr), .address(addr), .burstcount(bc), .byteenable(be),
      .writedata(wd), .waitrequest(wait1), .readdata(rdd1), .readdatavalid(rdv1)
   );

   pcie_cv_qsys_onchip_memory_burst #(
      .OUTPUT_REG(0), .READ_ONLY(1), .INIT_FILE("")
   ) u_ro (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .chipselect(cs),
      .read(rd), .write(wr), .address(addr), .burstcount(bc), .byteenable(be),
      .writedata(wd), .waitrequest(wait_ro), .readdata(rdd_ro), .readdatavalid(rdv_ro)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state
   logic [31:0] mm    [1024];
   bit          known [1024];
   int          m_rd_left = 0;
   int          m_wr_left = 0;
   logic [9:0]  m_addr = '0;
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   int          q_ro = 0;
   bit          armed = 1'b0;

   // per-cycle output logs for the directed timing checks
   bit          v0_log [1024];
   bit          v1_log [1024];
   bit          vro_log[1024];
   bit          w_log  [1024];
   logic [31:0] d0_log [1024];
   logic [31:0] d1_log [1024];
   logic [31:0] dro_log[1024];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad_val);
      total++;
      if (act === bad_val) begin
         bad++;
         $display("FAIL %s: got %h want anything but %h", name, act, bad_val);
      end
   endtask

   task automatic m_write(input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
      for (int i = 0; i < 4; i++) if (b[i]) mm[a][8*i +: 8] = d[8*i +: 8];
      if (b == 4'hF) known[a] = 1'b1;
   endtask

   task automatic m_read(input logic [9:0] a);
      q0.push_back({known[a], mm[a]});
      q1.push_back({known[a], mm[a]});
      q_ro++;
   endtask

   // Compare outputs against the model, then advance the model to the next edge.
   initial begin : cmp
      bit          st;
      logic [32:0] e;
      int          n;
      forever begin
         @(negedge clk);
         st = !clken || reset_req;
         if (cyc < 1024) begin
            v0_log[cyc]  = rdv0;   d0_log[cyc]  = rdd0;
            v1_log[cyc]  = rdv1;   d1_log[cyc]  = rdd1;
            vro_log[cyc] = rdv_ro; dro_log[cyc] = rdd_ro;
            w_log[cyc]   = wait0;
         end
         if (armed) begin
            chk("wait_rw0", wait0, st || (m_rd_left != 0));
            chk("wait_rw1", wait1, st || (m_rd_left != 0));
            chk("wait_ro", wait_ro, st || (m_rd_left != 0));
            if (st) begin
               chk("rdv0_stall", rdv0, 0);
               chk("rdv1_stall", rdv1, 0);
            end
            if (rdv0) begin
               if (q0.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rdv0_spurious: got readdatavalid=1 want 0");
               end else begin
                  e = q0.pop_front();
                  if (e[32]) chk("rdata_rw0", rdd0, e[31:0]);
               end
            end
            if (rdv1) begin
               if (q1.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rdv1_spurious: got readdatavalid=1 want 0");
               end else begin
                  e = q1.pop_front();
                  if (e[32]) chk("rdata_rw1", rdd1, e[31:0]);
               end
            end
            if (rdv_ro) begin
               if (q_ro == 0) begin
                  total++; bad++;
                  $display("FAIL rdv_ro_spurious: got readdatavalid=1 want 0");
               end else begin
                  q_ro--;
               end
            end
         end
         if (reset) begin
            m_rd_left = 0; m_wr_left = 0; m_addr = '0;
            q0.delete(); q1.delete(); q_ro = 0;
            armed = 1'b1;
         end else if (!st) begin
            if (m_rd_left != 0) begin
               m_read(m_addr);
               m_addr++;
               m_rd_left--;
            end else if (m_wr_left != 0) begin
               if (cs && wr) begin
                  m_write(m_addr, be, wd);
                  m_addr++;
                  m_wr_left--;
               end
            end else if (cs && (rd || wr)) begin
               n = (bc == 0) ? 1 : int'(bc);
               if (wr) begin
                  m_write(addr, be, wd);
                  m_wr_left = n - 1;
               end else begin
                  m_read(addr);
                  m_rd_left = n - 1;
               end
               m_addr = addr + 10'd1;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "timeout");
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs = 1'b0; rd = 1'b0; wr = 1'b0;
   endtask

   task automatic wr1(input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; bc = 4'd1; be = b; wd = d;
      go();
      idle();
   endtask

   task automatic rd1(input logic [9:0] a, output int t);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a; bc = 4'd1;
      t = cyc;
      go();
      idle();
      repeat (3) go();
   endtask

   initial begin : main
      int t;
      reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; bc = 4'd1; be = '0; wd = '0;
      repeat (3) go();
      reset = 1'b0;

      // post-reset state
      @(negedge clk);
      chk("rst_wait", wait0, 0);
      chk("rst_rdv0", rdv0, 0);
      chk("rst_rdata0", rdd0, 32'h0);
      chk("rst_rdata1", rdd1, 32'h0);
      go();

      // single write, single read; the first read attempt is frozen by reset_req
      wr1(10'd5, 4'hF, 32'hDEADBEEF);
      cs = 1'b1; rd = 1'b1; addr = 10'd5; bc = 4'd1; reset_req = 1'b1;
      go();
      reset_req = 1'b0;
      t = cyc;
      go();
      idle();
      repeat (4) go();
      chk("stall_wait", w_log[t-1], 1);
      chk("a_v0_T", v0_log[t], 0);
      chk("a_v0_T1", v0_log[t+1], 1);
      chk("a_d0_T1", d0_log[t+1], 32'hDEADBEEF);
      chk("a_v0_T2", v0_log[t+2], 0);
      chk("a_v1_T1", v1_log[t+1], 0);
      chk("a_v1_T2", v1_log[t+2], 1);
      chk("a_d1_T2", d1_log[t+2], 32'hDEADBEEF);

      // wrapping write burst with a gap cycle (stray read ignored)
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 10'h3FE; bc = 4'd4; be = 4'hF; wd = 32'd1;
      go();
      wd = 32'd2; addr = 10'h123; bc = 4'd1;
      go();
      wr = 1'b0; rd = 1'b1;
      go();
      rd = 1'b0; wr = 1'b1; wd = 32'd3;
      go();
      wd = 32'd4;
      go();
      idle();
      go();
      cs = 1'b1; rd = 1'b1; addr = 10'h3FE; bc = 4'd4;
      t = cyc;
      go();
      idle();
      repeat (6) go();
      chk("b_w_T", w_log[t], 0);
      for (int k = 1; k <= 3; k++) chk("b_w_burst", w_log[t+k], 1);
      chk("b_w_T4", w_log[t+4], 0);
      for (int k = 0; k < 4; k++) begin
         chk("b_v0", v0_log[t+k+1], 1);
         chk("b_d0", d0_log[t+k+1], k + 1);
      end
      chk("b_v0_T5", v0_log[t+5], 0);

      // burstcount 0 is one beat; word 0 follows the wrap
      cs = 1'b1; rd = 1'b1; addr = 10'h000; bc = 4'd0;
      t = cyc;
      go();
      idle();
      repeat (3) go();
      chk("z_w_T1", w_log[t+1], 0);
      chk("z_v0_T1", v0_log[t+1], 1);
      chk("z_d0_T1", d0_log[t+1], 32'd3);
      chk("z_v0_T2", v0_log[t+2], 0);

      // read burst of 3 with clken low in cycle T+3
      cs = 1'b1; rd = 1'b1; addr = 10'h3FE; bc = 4'd3;
      t = cyc;
      go();
      idle();
      go();
      go();
      clken = 1'b0;
      go();
      clken = 1'b1;
      repeat (4) go();
      chk("c_v1_T2", v1_log[t+2], 1);
      chk("c_d1_T2", d1_log[t+2], 32'd1);
      chk("c_v1_T3", v1_log[t+3], 0);
      chk("c_d1_hold", d1_log[t+3], 32'd1);
      chk("c_v1_T4", v1_log[t+4], 1);
      chk("c_d1_T4", d1_log[t+4], 32'd2);
      chk("c_v1_T5", v1_log[t+5], 1);
      chk("c_d1_T5", d1_log[t+5], 32'd3);
      chk("c_v1_T6", v1_log[t+6], 0);
      chk("c_v0_T3", v0_log[t+3], 0);
      chk("c_d0_T4", d0_log[t+4], 32'd3);
      chk("c_w_T3", w_log[t+3], 1);

      // byte-enabled partial write; read-only instance must not take the data
      wr1(10'd9, 4'hF, 32'h11223344);
      wr1(10'd9, 4'h5, 32'hAABBCCDD);
      rd1(10'd9, t);
      chk("d_v0", v0_log[t+1], 1);
      chk("d_d0", d0_log[t+1], 32'h11BB33DD);
      chk("d_vro", vro_log[t+1], 1);
      chk_ne("d_dro", dro_log[t+1], 32'h11BB33DD);
      wr1(10'd9, 4'hF, 32'hAABBCCDD);
      rd1(10'd9, t);
      chk("d_d0_full", d0_log[t+1], 32'hAABBCCDD);
      chk_ne("d_dro_full", dro_log[t+1], 32'hAABBCCDD);

      // reset during beat 2 of an 8-beat read
      cs = 1'b1; rd = 1'b1; addr = 10'h3FE; bc = 4'd8;
      t = cyc;
      go();
      idle();
      go();
      reset = 1'b1;
      go();
      reset = 1'b0;
      repeat (8) go();
      chk("e_w_T3", w_log[t+3], 0);
      chk("e_d0_T3", d0_log[t+3], 32'h0);
      chk("e_d1_T3", d1_log[t+3], 32'h0);
      for (int k = 3; k <= 10; k++) begin
         chk("e_v0_dead", v0_log[t+k], 0);
         chk("e_v1_dead", v1_log[t+k], 0);
      end
      rd1(10'h3FE, t);
      chk("e_d0_intact", d0_log[t+1], 32'd1);

      // read and write together: write wins, read dropped
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 10'd7; bc = 4'd1; be = 4'hF; wd = 32'h5;
      t = cyc;
      go();
      idle();
      repeat (3) go();
      for (int k = 1; k <= 3; k++) chk("f_v0_none", v0_log[t+k], 0);
      rd1(10'd7, t);
      chk("f_d0", d0_log[t+1], 32'h5);

      repeat (3) go();
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      chk("drain_ro", q_ro, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
